// File: rtl/caliptra_fpga_sync_axil_arb.sv
// 2:1 AXI4-Lite arbiter in front of the FPGA sync block's AXI4-Lite slave.
// Read and write paths are arbitrated independently with round-robin, and each
// allows one outstanding transaction. There is no payload buffering: downstream
// valids and payloads are routed combinationally from the granted requester.
//
// Ports (index i of a 2-wide vector is requester i):
//   aclk, rst                     clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*               upstream write channels, two requesters packed
//   s_ar*/s_r*                    upstream read channels, two requesters packed
//   m_aw*/m_w*/m_b*/m_ar*/m_r*    single downstream AXI4-Lite master
//   wr_gnt, rd_gnt                one-hot current grant, 0 when the path is idle
module caliptra_fpga_sync_axil_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic                  aclk,
  input  logic                  rst,
  // Upstream write address / data / response
  input  logic [1:0]            s_awvalid,
  input  logic [2*ADDR_W-1:0]   s_awaddr,
  input  logic [5:0]            s_awprot,
  output logic [1:0]            s_awready,
  input  logic [1:0]            s_wvalid,
  input  logic [2*DATA_W-1:0]   s_wdata,
  input  logic [2*STRB_W-1:0]   s_wstrb,
  output logic [1:0]            s_wready,
  output logic [1:0]            s_bvalid,
  output logic [3:0]            s_bresp,
  input  logic [1:0]            s_bready,
  // Upstream read address / data
  input  logic [1:0]            s_arvalid,
  input  logic [2*ADDR_W-1:0]   s_araddr,
  input  logic [5:0]            s_arprot,
  output logic [1:0]            s_arready,
  output logic [1:0]            s_rvalid,
  output logic [2*DATA_W-1:0]   s_rdata,
  output logic [3:0]            s_rresp,
  input  logic [1:0]            s_rready,
  // Downstream master
  output logic                  m_awvalid,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [2:0]            m_awprot,
  input  logic                  m_awready,
  output logic                  m_wvalid,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [STRB_W-1:0]     m_wstrb,
  input  logic                  m_wready,
  input  logic                  m_bvalid,
  input  logic [1:0]            m_bresp,
  output logic                  m_bready,
  output logic                  m_arvalid,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [2:0]            m_arprot,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  output logic                  m_rready,
  // Status
  output logic [1:0]            wr_gnt,
  output logic [1:0]            rd_gnt
);

  typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;

  state_e wr_state_q, wr_state_d;
  state_e rd_state_q, rd_state_d;
  logic   wr_sel_q, wr_sel_d, wr_last_q, wr_last_d;
  logic   aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic   rd_sel_q, rd_sel_d, rd_last_q, rd_last_d;
  logic   aw_hs, w_hs;

  // On a tie the port that did not win last time goes; otherwise the lone requester.
  function automatic logic pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  // ---------------------------------------------------------------- write path
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      wr_state_q <= StIdle;
      wr_sel_q   <= 1'b0;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_sel_q   <= wr_sel_d;
      wr_last_q  <= wr_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_sel_d   = wr_sel_q;
    wr_last_d  = wr_last_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    s_awready  = '0;
    s_wready   = '0;
    s_bvalid   = '0;
    s_bresp    = '0;
    m_awvalid  = 1'b0;
    m_awaddr   = '0;
    m_awprot   = '0;
    m_wvalid   = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_bready   = 1'b0;
    unique case (wr_state_q)
      StIdle: begin
        if (|s_awvalid) begin
          wr_sel_d   = pick(s_awvalid, wr_last_q);
          wr_state_d = StAddr;
        end
      end
      StAddr: begin
        m_awvalid = s_awvalid[wr_sel_q] & ~aw_done_q;
        m_awaddr  = s_awaddr[ADDR_W*wr_sel_q +: ADDR_W];
        m_awprot  = s_awprot[3*wr_sel_q +: 3];
        m_wvalid  = s_wvalid[wr_sel_q] & ~w_done_q;
        m_wdata   = s_wdata[DATA_W*wr_sel_q +: DATA_W];
        m_wstrb   = s_wstrb[STRB_W*wr_sel_q +: STRB_W];
        s_awready[wr_sel_q] = m_awready & ~aw_done_q;
        s_wready[wr_sel_q]  = m_wready & ~w_done_q;
        aw_hs = m_awvalid & m_awready;
        w_hs  = m_wvalid & m_wready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // AW and W may finish in either order, or together.
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) wr_state_d = StResp;
      end
      StResp: begin
        s_bvalid[wr_sel_q]        = m_bvalid;
        s_bresp[2*wr_sel_q +: 2]  = m_bresp;
        m_bready                  = s_bready[wr_sel_q];
        if (m_bvalid & s_bready[wr_sel_q]) begin
          wr_state_d = StIdle;
          wr_last_d  = wr_sel_q;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      default: wr_state_d = StIdle;
    endcase
  end

  assign wr_gnt = (wr_state_q == StIdle) ? 2'b00 : (wr_sel_q ? 2'b10 : 2'b01);

  // ----------------------------------------------------------------- read path
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      rd_state_q <= StIdle;
      rd_sel_q   <= 1'b0;
      rd_last_q  <= 1'b1;
    end else begin
      rd_state_q <= rd_state_d;
      rd_sel_q   <= rd_sel_d;
      rd_last_q  <= rd_last_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_sel_d   = rd_sel_q;
    rd_last_d  = rd_last_q;
    s_arready  = '0;
    s_rvalid   = '0;
    s_rdata    = '0;
    s_rresp    = '0;
    m_arvalid  = 1'b0;
    m_araddr   = '0;
    m_arprot   = '0;
    m_rready   = 1'b0;
    unique case (rd_state_q)
      StIdle: begin
        if (|s_arvalid) begin
          rd_sel_d   = pick(s_arvalid, rd_last_q);
          rd_state_d = StAddr;
        end
      end
      StAddr: begin
        m_arvalid           = s_arvalid[rd_sel_q];
        m_araddr            = s_araddr[ADDR_W*rd_sel_q +: ADDR_W];
        m_arprot            = s_arprot[3*rd_sel_q +: 3];
        s_arready[rd_sel_q] = m_arready;
        if (m_arvalid & m_arready) rd_state_d = StResp;
      end
      StResp: begin
        s_rvalid[rd_sel_q]                = m_rvalid;
        s_rdata[DATA_W*rd_sel_q +: DATA_W] = m_rdata;
        s_rresp[2*rd_sel_q +: 2]           = m_rresp;
        m_rready                           = s_rready[rd_sel_q];
        if (m_rvalid & s_rready[rd_sel_q]) begin
          rd_state_d = StIdle;
          rd_last_d  = rd_sel_q;
        end
      end
      default: rd_state_d = StIdle;
    endcase
  end

  assign rd_gnt = (rd_state_q == StIdle) ? 2'b00 : (rd_sel_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_caliptra_fpga_sync_axil_arb.sv
// Scoreboard bench for the 2:1 AXI4-Lite arbiter. Requester tasks push the
// expected response into a per-port queue when they issue; a monitor pops and
// compares whenever an upstream B or R handshake appears. A small slave model
// with byte-strobed memory sits on the downstream side.
module tb_caliptra_fpga_sync_axil_arb;

  logic         aclk = 1'b0;
  logic         rst  = 1'b1;
  logic [1:0]   s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [63:0]  s_awaddr, s_araddr;
  logic [5:0]   s_awprot, s_arprot;
  logic [127:0] s_wdata, s_rdata;
  logic [15:0]  s_wstrb;
  logic [3:0]   s_bresp, s_rresp;
  logic [1:0]   s_arvalid, s_arready, s_rvalid, s_rready;
  logic         m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic         m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0]  m_awaddr, m_araddr;
  logic [2:0]   m_awprot, m_arprot;
  logic [63:0]  m_wdata, m_rdata;
  logic [7:0]   m_wstrb;
  logic [1:0]   m_bresp, m_rresp, wr_gnt, rd_gnt;

  logic aw_rdy_en, w_rdy_en;
  int   bdelay;
  assign m_awready = aw_rdy_en;
  assign m_wready  = w_rdy_en;
  assign m_arready = 1'b1;

  caliptra_fpga_sync_axil_arb dut (
    .aclk(aclk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
  );

  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Every valid/ready output plus both grants; all must be 0 in reset.
  logic [18:0] vr_bundle;
  assign vr_bundle = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s_awready, s_wready,
                      s_bvalid, s_arready, s_rvalid, wr_gnt, rd_gnt};

  // ------------------------------------------------------------ slave model
  logic [63:0] mem [logic [31:0]];

  initial begin : slave
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w;
    logic [31:0] wa, ra;
    logic [63:0] wd, cur;
    logic [7:0]  ws;
    int          cnt;
    mem[32'h2000] = 64'hDEAD_BEEF_CAFE_F00D;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    got_aw = 1'b0; got_w = 1'b0; cnt = 0; wa = '0; ra = '0; wd = '0; ws = '0;
    forever begin
      @(negedge aclk);
      aw_hs = m_awvalid & m_awready;
      w_hs  = m_wvalid & m_wready;
      b_hs  = m_bvalid & m_bready;
      ar_hs = m_arvalid & m_arready;
      r_hs  = m_rvalid & m_rready;
      if (aw_hs) wa = m_awaddr;
      if (w_hs) begin wd = m_wdata; ws = m_wstrb; end
      if (ar_hs) ra = m_araddr;
      @(posedge aclk);
      #1;
      if (rst) begin
        m_bvalid = 1'b0; m_rvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0; cnt = 0;
      end else begin
        if (aw_hs) got_aw = 1'b1;
        if (w_hs)  got_w  = 1'b1;
        if (b_hs)  m_bvalid = 1'b0;
        if (got_aw && got_w) begin
          if (cnt >= bdelay) begin
            cur = mem.exists(wa) ? mem[wa] : 64'h0;
            for (int i = 0; i < 8; i++) if (ws[i]) cur[i*8 +: 8] = wd[i*8 +: 8];
            mem[wa]  = cur;
            m_bvalid = 1'b1;
            m_bresp  = (wa == 32'h3000) ? 2'b10 : 2'b00;
            got_aw = 1'b0; got_w = 1'b0; cnt = 0;
          end else begin
            cnt++;
          end
        end
        if (r_hs) m_rvalid = 1'b0;
        if (ar_hs) begin
          m_rvalid = 1'b1;
          m_rdata  = mem.exists(ra) ? mem[ra] : 64'h0;
          m_rresp  = 2'b00;
        end
      end
    end
  end

  // ---------------------------------------------------- scoreboard / monitor
  logic [1:0]  exp_b0 [$];
  logic [1:0]  exp_b1 [$];
  logic [65:0] exp_r0 [$];
  logic [65:0] exp_r1 [$];
  logic [1:0]  gnt_log [$];
  int b_seen [2];
  int r_seen [2];
  int b_hs_cyc [2];
  int w_hs_cyc, aw_hs_cyc, awv_rise, gnt1_cyc, awrdy1_cyc;

  initial begin : monitor
    logic [1:0]  eb, prev_gnt;
    logic [65:0] er;
    logic        prev_awv, prev_awrdy1, empty;
    b_seen = '{0, 0}; r_seen = '{0, 0}; b_hs_cyc = '{0, 0};
    w_hs_cyc = 0; aw_hs_cyc = 0; awv_rise = 0; gnt1_cyc = 0; awrdy1_cyc = 0;
    prev_gnt = 2'b00; prev_awv = 1'b0; prev_awrdy1 = 1'b0;
    forever begin
      @(negedge aclk);
      if (!rst) begin
        // A port without the grant must see no ready or valid at all.
        chk("isolation", {s_awready & ~wr_gnt, s_wready & ~wr_gnt, s_bvalid & ~wr_gnt,
                          s_arready & ~rd_gnt, s_rvalid & ~rd_gnt}, '0);
        for (int p = 0; p < 2; p++) begin
          if (s_bvalid[p] && s_bready[p]) begin
            empty = (p == 0) ? (exp_b0.size() == 0) : (exp_b1.size() == 0);
            if (empty) begin
              n_chk++; n_err++;
              $display("FAIL b_unexpected_p%0d: got bvalid=1 expected none", p);
            end else begin
              if (p == 0) eb = exp_b0.pop_front(); else eb = exp_b1.pop_front();
              chk($sformatf("bresp_p%0d", p), s_bresp[2*p +: 2], eb);
            end
            b_seen[p]++;
            b_hs_cyc[p] = cyc;
          end
          if (s_rvalid[p] && s_rready[p]) begin
            empty = (p == 0) ? (exp_r0.size() == 0) : (exp_r1.size() == 0);
            if (empty) begin
              n_chk++; n_err++;
              $display("FAIL r_unexpected_p%0d: got rvalid=1 expected none", p);
            end else begin
              if (p == 0) er = exp_r0.pop_front(); else er = exp_r1.pop_front();
              chk($sformatf("rdata_p%0d", p), {s_rresp[2*p +: 2], s_rdata[64*p +: 64]}, er);
            end
            r_seen[p]++;
          end
        end
        if (m_wvalid && m_wready) w_hs_cyc = cyc;
        if (m_awvalid && m_awready) aw_hs_cyc = cyc;
        if (m_awvalid && !prev_awv) awv_rise++;
        if (wr_gnt != 2'b00 && wr_gnt != prev_gnt) gnt_log.push_back(wr_gnt);
        if (wr_gnt == 2'b10 && prev_gnt != 2'b10) gnt1_cyc = cyc;
        if (s_awready[1] && !prev_awrdy1) awrdy1_cyc = cyc;
      end
      prev_gnt = wr_gnt; prev_awv = m_awvalid; prev_awrdy1 = s_awready[1];
    end
  end

  // --------------------------------------------------------- requester tasks
  task automatic wr(input int p, input logic [31:0] a, input logic [63:0] d,
                    input logic [7:0] s, input int lead, input logic [1:0] er);
    logic awh, wh, aw_on, w_on;
    int   t, start;
    start = b_seen[p];
    if (p == 0) exp_b0.push_back(er); else exp_b1.push_back(er);
    s_wdata[64*p +: 64] = d; s_wstrb[8*p +: 8] = s; s_wvalid[p] = 1'b1; w_on = 1'b1;
    aw_on = 1'b0;
    repeat (lead) begin
      @(negedge aclk);
      wh = s_wvalid[p] & s_wready[p];
      tick();
      if (wh) begin s_wvalid[p] = 1'b0; w_on = 1'b0; end
    end
    s_awaddr[32*p +: 32] = a; s_awprot[3*p +: 3] = 3'(p + 2); s_awvalid[p] = 1'b1; aw_on = 1'b1;
    t = 0;
    while ((aw_on || w_on) && t < 200) begin
      @(negedge aclk);
      awh = s_awvalid[p] & s_awready[p];
      wh  = s_wvalid[p] & s_wready[p];
      tick();
      if (awh) begin s_awvalid[p] = 1'b0; aw_on = 1'b0; end
      if (wh)  begin s_wvalid[p]  = 1'b0; w_on  = 1'b0; end
      t++;
    end
    chk($sformatf("wr_addr_data_taken_p%0d", p), {aw_on, w_on}, 2'b00);
    s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0;
    t = 0;
    while (b_seen[p] == start && t < 200) begin tick(); t++; end
    chk($sformatf("wr_b_arrived_p%0d", p), 128'(b_seen[p] - start), 1);
  endtask

  task automatic rd(input int p, input logic [31:0] a, input logic [63:0] ed);
    logic arh, on;
    int   t, start;
    start = r_seen[p];
    if (p == 0) exp_r0.push_back({2'b00, ed}); else exp_r1.push_back({2'b00, ed});
    s_araddr[32*p +: 32] = a; s_arprot[3*p +: 3] = 3'(p + 4); s_arvalid[p] = 1'b1; on = 1'b1;
    t = 0;
    while (on && t < 200) begin
      @(negedge aclk);
      arh = s_arvalid[p] & s_arready[p];
      tick();
      if (arh) begin s_arvalid[p] = 1'b0; on = 1'b0; end
      t++;
    end
    chk($sformatf("rd_addr_taken_p%0d", p), on, 1'b0);
    s_arvalid[p] = 1'b0;
    t = 0;
    while (r_seen[p] == start && t < 200) begin tick(); t++; end
    chk($sformatf("rd_r_arrived_p%0d", p), 128'(r_seen[p] - start), 1);
  endtask

  logic [1:0] exp_ord [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  // ------------------------------------------------------------------ tests
  initial begin : main
    int aw_before;
    s_awvalid = '0; s_awaddr = '0; s_awprot = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0;
    s_arvalid = '0; s_araddr = '0; s_arprot = '0; s_bready = 2'b11; s_rready = 2'b11;
    aw_rdy_en = 1'b1; w_rdy_en = 1'b1; bdelay = 0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", vr_bundle, '0);
    rst = 1'b0;
    tick();

    // Simultaneous requests from reset: port 0 first, then alternation.
    gnt_log.delete();
    fork
      wr(0, 32'h100, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 2'b00);
      wr(1, 32'h108, 64'h1111_2222_3333_4444, 8'hFF, 0, 2'b00);
    join
    fork
      wr(0, 32'h110, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 0, 2'b00);
      wr(1, 32'h118, 64'h0F0F_F0F0_0F0F_F0F0, 8'hFF, 0, 2'b00);
    join
    chk("rr_count", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order_%0d", i), gnt_log[i], exp_ord[i]);
    rd(1, 32'h100, 64'h0123_4567_89AB_CDEF);
    rd(0, 32'h108, 64'h1111_2222_3333_4444);
    rd(1, 32'h110, 64'hA5A5_A5A5_5A5A_5A5A);
    rd(0, 32'h118, 64'h0F0F_F0F0_0F0F_F0F0);
    // Low four byte strobes only.
    wr(1, 32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 2'b00);
    rd(0, 32'h100, 64'h0123_4567_FFFF_FFFF);

    // Port 0 alone: one cycle of grant latency, payload routed from port 0.
    fork
      wr(0, 32'h1000, 64'h1122_3344_5566_7788, 8'hFF, 0, 2'b00);
      begin
        @(negedge aclk);
        chk("t1_idle_awvalid", {m_awvalid, wr_gnt}, 3'b000);
        @(negedge aclk);
        chk("t1_awvalid", m_awvalid, 1'b1);
        chk("t1_wr_gnt", wr_gnt, 2'b01);
        chk("t1_aw_payload", {m_awaddr, m_awprot}, {32'h1000, 3'b010});
        chk("t1_w_payload", {m_wdata, m_wstrb}, {64'h1122_3344_5566_7788, 8'hFF});
        chk("t1_p1_readies", {s_awready[1], s_wready[1]}, 2'b00);
      end
    join
    rd(0, 32'h1000, 64'h1122_3344_5566_7788);
    // Error response routed back to port 1 only.
    wr(1, 32'h3000, 64'h0, 8'hFF, 0, 2'b10);

    // W three cycles ahead of AW; AW held off downstream so W completes first.
    aw_rdy_en = 1'b0;
    aw_before = awv_rise;
    fork
      wr(0, 32'h5000, 64'h5000_5000_5000_5000, 8'hFF, 3, 2'b00);
      begin repeat (7) tick(); aw_rdy_en = 1'b1; end
    join
    chk("t3_w_before_aw", 128'(w_hs_cyc < aw_hs_cyc), 1);
    chk("t3_single_aw_pulse", 128'(awv_rise - aw_before), 1);
    rd(1, 32'h5000, 64'h5000_5000_5000_5000);

    // Concurrent read on port 1 and write on port 0.
    fork
      rd(1, 32'h2000, 64'hDEAD_BEEF_CAFE_F00D);
      wr(0, 32'h6000, 64'h6666_7777_8888_9999, 8'hFF, 0, 2'b00);
      begin
        @(negedge aclk);
        @(negedge aclk);
        chk("t4_grants", {rd_gnt, wr_gnt}, 4'b1001);
      end
    join

    // Slow B for port 0 while port 1 waits; port 1 is let in right after.
    bdelay = 10;
    fork
      wr(0, 32'h4000, 64'h4040_4040_4040_4040, 8'hFF, 0, 2'b00);
      begin
        tick(); tick();
        wr(1, 32'h4008, 64'h4848_4848_4848_4848, 8'hFF, 0, 2'b00);
      end
    join
    bdelay = 0;
    // B handshake in cycle c, IDLE in c+1, port 1 granted and ready in c+2.
    chk("t5_grant_cycle", 128'(gnt1_cyc), 128'(b_hs_cyc[0] + 2));
    chk("t5_awready_cycle", 128'(awrdy1_cyc), 128'(b_hs_cyc[0] + 2));

    // Reset in ADDR after AW has completed but W has not.
    w_rdy_en = 1'b0;
    s_awaddr[31:0] = 32'h7000; s_awvalid[0] = 1'b1;
    s_wdata[63:0] = 64'h7777; s_wstrb[7:0] = 8'hFF; s_wvalid[0] = 1'b1;
    tick();
    tick();
    s_awvalid[0] = 1'b0;
    @(negedge aclk);
    chk("t6_addr_state", {m_awvalid, m_wvalid, wr_gnt}, 4'b0101);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_reset_outputs", vr_bundle, '0);
    s_wvalid[0] = 1'b0;
    tick(); tick();
    rst = 1'b0; w_rdy_en = 1'b1;
    tick();
    gnt_log.delete();
    fork
      wr(0, 32'h7008, 64'h7008_7008_7008_7008, 8'hFF, 0, 2'b00);
      wr(1, 32'h7010, 64'h7010_7010_7010_7010, 8'hFF, 0, 2'b00);
      begin
        @(negedge aclk);
        @(negedge aclk);
        chk("t6_regrant", wr_gnt, 2'b01);
      end
    join
    chk("t6_order", {gnt_log[0], gnt_log[1]}, 4'b0110);
    rd(0, 32'h7000, 64'h0);

    repeat (3) tick();
    chk("queues_drained", 128'(exp_b0.size() + exp_b1.size() + exp_r0.size() + exp_r1.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
